// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (priority,
// combinational pass-through) and a FIFO of buffered IO writes with starvation stall.
module regfile_write_arbiter #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int DEPTH        = 4,
  parameter int MAXWAIT      = 8,
  parameter logic [ADDRESSWIDTH-1:0] RSVDADDR = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [ADDRESSWIDTH-1:0]  wb_wa,
  input  logic [WIDTH-1:0]         wb_wd,
  input  logic                     io_valid,
  output logic                     io_ready,
  input  logic [ADDRESSWIDTH-1:0]  io_wa,
  input  logic [WIDTH-1:0]         io_wd,
  output logic                     we3,
  output logic [ADDRESSWIDTH-1:0]  wa3,
  output logic [WIDTH-1:0]         wd3,
  output logic                     stall,
  output logic                     drop_err,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (MAXWAIT > 2) ? $clog2(MAXWAIT) : 1;
  localparam int EW = ADDRESSWIDTH + WIDTH;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          stall_q, stall_d;
  logic          drop_err_q, drop_err_d;

  logic                    fifo_empty;
  logic                    io_gnt;
  logic                    wb_gnt;
  logic                    any_gnt;
  logic                    rsvd_hit;
  logic                    push;
  logic [ADDRESSWIDTH-1:0] head_wa;
  logic [WIDTH-1:0]        head_wd;
  logic [ADDRESSWIDTH-1:0] gnt_wa;
  logic [WIDTH-1:0]        gnt_wd;

  assign fifo_empty = (count_q == '0);
  assign io_ready   = (count_q < CW'(DEPTH));
  assign push       = io_valid && io_ready;
  assign {head_wa, head_wd} = mem_q[rd_ptr_q];

  // A stall cycle always drains the FIFO head, so wb_we is ignored there.
  assign io_gnt  = !fifo_empty && (stall_q || !wb_we);
  assign wb_gnt  = !io_gnt && wb_we;
  assign any_gnt = io_gnt || wb_gnt;

  assign gnt_wa   = io_gnt ? head_wa : wb_wa;
  assign gnt_wd   = io_gnt ? head_wd : wb_wd;
  assign rsvd_hit = any_gnt && (gnt_wa == RSVDADDR);

  assign we3 = any_gnt && !rsvd_hit && !rst;
  assign wa3 = any_gnt ? gnt_wa : '0;
  assign wd3 = any_gnt ? gnt_wd : '0;

  assign stall    = stall_q;
  assign drop_err = drop_err_q;
  assign io_count = count_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wait_cnt_d = wait_cnt_q;
    stall_d    = 1'b0;
    drop_err_d = rsvd_hit;

    if (io_gnt) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, io_gnt})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (fifo_empty || io_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WW'(MAXWAIT - 1)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    stall_d = !fifo_empty && !io_gnt && (wait_cnt_q == WW'(MAXWAIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {io_wa, io_wd};
  end

endmodule
